// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives a ROM-style request port from a program counter,
// buffers fetched words with their PC, and hands them to decode through valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_cs,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int                 PTR_W   = $clog2(DEPTH);
  localparam int                 CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DEPTH);
  localparam logic [31:0]        NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } state_e;

  state_e             state_q;
  logic [31:0]        fetch_pc_q;
  logic [31:0]        mem_addr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic [31:0]        instr_mem [DEPTH];
  logic [31:0]        pc_mem    [DEPTH];

  logic        done;
  logic        pop;
  logic        push;
  logic [31:0] redir_pc;
  logic [31:0] fetch_pc_inc;

  assign mem_cs       = (state_q != IDLE);
  assign mem_addr     = mem_addr_q;
  assign done         = mem_cs && mem_ready;
  assign out_valid    = (count_q != '0);
  // A redirect flushes the buffer, so any pop or push in the same cycle is void.
  assign pop          = out_valid && out_ready && !redirect_valid;
  assign push         = (state_q == REQ) && done && !redirect_valid;
  assign redir_pc     = redirect_pc & ~32'h0000_0003;
  assign fetch_pc_inc = fetch_pc_q + 32'd4;

  // Empty-buffer outputs are forced to a NOP at PC 0 so storage needs no reset.
  assign out_instr = out_valid ? instr_mem[rd_ptr_q] : NOP;
  assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : '0;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (redirect_valid) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in the block sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc_q <= redir_pc;
      if (mem_cs && !done) begin
        // The bus cannot be abandoned mid-request: hold the stale address and drop its data.
        state_q <= DISCARD;
      end else begin
        state_q    <= REQ;
        mem_addr_q <= redir_pc;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q < DEPTH_C) begin
            state_q    <= REQ;
            mem_addr_q <= fetch_pc_q;
          end
        end
        REQ: begin
          if (done) begin
            fetch_pc_q <= fetch_pc_inc;
            mem_addr_q <= fetch_pc_inc;
            state_q    <= (count_d < DEPTH_C) ? REQ : IDLE;
          end
        end
        DISCARD: begin
          if (done) begin
            state_q    <= REQ;
            mem_addr_q <= fetch_pc_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (redirect_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
    end
  end

  // NOTE: buffer storage is deliberately not reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= mem_rdata;
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized phase,
// checked against an in-order delivered-PC stream model and a bus-protocol model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] ROM_KEY  = 32'hA5A5_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_cs;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pops   = 0;

  // ROM responder: word = addr ^ key, ready after `lat` wait cycles or at random.
  int lat       = 0;
  bit rand_mode = 1'b0;
  int wait_cnt  = 0;
  bit rnd_bit   = 1'b1;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_cs         (mem_cs),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr ^ ROM_KEY;
  assign mem_ready = rand_mode ? rnd_bit : (wait_cnt >= lat);

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rnd_bit <= ($urandom_range(0, 3) != 0);
    if (mem_cs && !mem_ready) wait_cnt <= wait_cnt + 1;
    else                      wait_cnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: decode sees an unbroken PC stream that restarts at the
  // redirect target (or RESET_PC), each word equal to pc ^ key.
  logic [31:0] exp_pc     = RESET_PC;
  bit          prev_wait  = 1'b0;
  bit          prev_hold  = 1'b0;
  logic [31:0] prev_addr  = '0;
  logic [31:0] prev_pc    = '0;
  logic [31:0] prev_instr = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_pc    = RESET_PC;
      prev_wait = 1'b0;
      prev_hold = 1'b0;
    end else begin
      check("addr_align", {30'b0, mem_addr[1:0]}, 32'd0);
      if (prev_wait) begin
        check("wait_cs_held", 32'(mem_cs), 32'd1);
        check("wait_addr_held", mem_addr, prev_addr);
      end
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_pc", out_pc, prev_pc);
        check("hold_instr", out_instr, prev_instr);
      end
      if (redirect_valid) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (out_valid && out_ready) begin
        check("pop_pc", out_pc, exp_pc);
        check("pop_instr", out_instr, exp_pc ^ ROM_KEY);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      prev_wait  = mem_cs && !mem_ready;
      prev_addr  = mem_addr;
      prev_hold  = out_valid && !out_ready && !redirect_valid;
      prev_pc    = out_pc;
      prev_instr = out_instr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic wait_pop(input string tag, input int budget,
                          output logic [31:0] pc, output logic [31:0] instr, output int at);
    bit got = 1'b0;
    pc    = '0;
    instr = '0;
    at    = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got   = 1'b1;
        pc    = out_pc;
        instr = out_instr;
        at    = cyc;
      end
    end
    check({tag, "_timeout"}, 32'(got), 32'd1);
  endtask

  task automatic wait_stall(input string tag, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (mem_cs && !mem_ready) got = 1'b1;
    end
    check({tag, "_timeout"}, 32'(got), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] pc, instr, tgt;
    int          t0, t1;

    // Reset values and sequential fetch.
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst_cs", 32'(mem_cs), 32'd0);
    check("rst_addr", mem_addr, RESET_PC);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_instr", out_instr, NOP);
    check("rst_pc", out_pc, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("seq_cs_cycle1", 32'(mem_cs), 32'd0);
    @(negedge clk);
    check("seq_cs_cycle2", 32'(mem_cs), 32'd1);
    check("seq_addr_first", mem_addr, RESET_PC);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("seq_valid", 32'(out_valid), 32'd1);
      check("seq_pc", out_pc, RESET_PC + 32'(4 * i));
      check("seq_instr", out_instr, (RESET_PC + 32'(4 * i)) ^ ROM_KEY);
    end

    // Backpressure from the start: two entries buffered, fetch parked at PC 8.
    tick();
    out_ready = 1'b0;
    do_reset(2);
    repeat (6) @(negedge clk);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_head_pc", out_pc, 32'h0);
    check("bp_cs_idle", 32'(mem_cs), 32'd0);
    check("bp_addr_parked", mem_addr, 32'h8);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_pop0", out_pc, 32'h0);
    wait_pop("bp_pop4", 4, pc, instr, t0);
    check("bp_pop4_pc", pc, 32'h4);
    wait_pop("bp_pop8", 6, pc, instr, t0);
    check("bp_pop8_pc", pc, 32'h8);

    // Three wait states per request: one instruction every four cycles.
    tick();
    lat = 3;
    do_reset(2);
    wait_pop("ws_first", 20, pc, instr, t0);
    check("ws_first_pc", pc, RESET_PC);
    wait_pop("ws_second", 20, pc, instr, t1);
    check("ws_second_pc", pc, RESET_PC + 32'd4);
    check("ws_interval", 32'(t1 - t0), 32'd4);

    // Redirect during a wait state: old word dropped, restart at 0x100.
    wait_stall("rif_stall", 20);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rif_flushed", 32'(out_valid), 32'd0);
    check("rif_discard_cs", 32'(mem_cs), 32'd1);
    wait_pop("rif_next", 30, pc, instr, t0);
    check("rif_next_pc", pc, 32'h0000_0100);
    check("rif_next_instr", instr, 32'h0000_0100 ^ ROM_KEY);

    // Redirect coincident with a pop and a completing request.
    tick();
    lat = 0;
    repeat (4) tick();
    check("coinc_setup", 32'(mem_cs && mem_ready && out_valid && out_ready), 32'd1);
    tgt            = $urandom;
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("coinc_flushed", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("coinc_valid", 32'(out_valid), 32'd1);
    check("coinc_pc", out_pc, {tgt[31:2], 2'b00});
    check("coinc_instr", out_instr, {tgt[31:2], 2'b00} ^ ROM_KEY);

    // PC wrap at the top of the address space.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("wrap_flushed", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("wrap_pc_top", out_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_pc_zero", out_pc, 32'h0);
    check("wrap_instr_zero", out_instr, ROM_KEY);

    // Reset in the middle of a wait state abandons the request.
    tick();
    lat = 3;
    wait_stall("rmw_stall", 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rmw_valid", 32'(out_valid), 32'd0);
    check("rmw_cs", 32'(mem_cs), 32'd0);
    check("rmw_addr", mem_addr, RESET_PC);
    wait_pop("rmw_refetch", 20, pc, instr, t0);
    check("rmw_refetch_pc", pc, RESET_PC);

    // Randomized traffic: ready, backpressure, redirects and occasional resets.
    t0        = pops;
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 31) == 0);
      redirect_pc    = $urandom;
      rst            = ($urandom_range(0, 299) == 0);
    end
    tick();
    redirect_valid = 1'b0;
    rst            = 1'b0;
    out_ready      = 1'b1;
    rand_mode      = 1'b0;
    lat            = 0;
    wait_pop("drain", 10, pc, instr, t1);
    check("rand_progress", 32'(pops - t0 > 500), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
